instr_fetch_unit: RTL

//  Upstream neighbour of the control logic in the 32-bit MIPS core. Holds the PC, fetches
//  one word per instruction from instruction memory over a req/ack handshake, and presents

---
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC holder and req/ack instruction fetch for the MIPS core
// Optional FETCH_PERF_EN adds retire_cnt and stall_cnt performance counters.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] HALT_INSTR  = 32'hFC00_0000,
   parameter int          ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc_in,
   input  logic        stall_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instrn,
   output logic [5:0]  instrn_opcode,
   output logic [31:0] address_plus_4,
   output logic        instrn_valid,
   output logic        halted,
   output logic        misalign_err,
   output logic        fetch_err
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] retire_cnt,
   output logic [31:0] stall_cnt
`endif
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, EXEC, HALT} state_t;

   state_t        state;
   logic [31:0]   pc;
   logic [CW-1:0] cnt;

   assign imem_addr      = pc;
   assign address_plus_4 = pc + 32'd4;
   assign instrn_opcode  = instrn[31:26];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         instrn       <= '0;
         imem_req     <= 1'b0;
         instrn_valid <= 1'b0;
         halted       <= 1'b0;
         misalign_err <= 1'b0;
         fetch_err    <= 1'b0;
         cnt          <= '0;
      end else begin
         case (state)
            IDLE: begin
               state    <= REQ;
               imem_req <= 1'b1;
            end
            REQ, WAIT: begin
               if (imem_ack) begin
                  instrn   <= imem_rdata;
                  imem_req <= 1'b0;
                  cnt      <= '0;
                  // A halt word is captured but never presented as valid
                  if (imem_rdata == HALT_INSTR) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end else begin
                     state        <= EXEC;
                     instrn_valid <= 1'b1;
                  end
               end else if (state == REQ) begin
                  state <= WAIT;
                  cnt   <= CW'(1);
               end else if (cnt == CW'(ACK_TIMEOUT)) begin
                  state     <= HALT;
                  imem_req  <= 1'b0;
                  fetch_err <= 1'b1;
                  halted    <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            EXEC: begin
               if (!stall_in) begin
                  instrn_valid <= 1'b0;
                  if (next_pc_in[1:0] != 2'b00) begin
                     state        <= HALT;
                     misalign_err <= 1'b1;
                     halted       <= 1'b1;
                  end else begin
                     pc       <= next_pc_in;
                     state    <= REQ;
                     imem_req <= 1'b1;
                  end
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= HALT;
               halted <= 1'b1;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retire_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (state == EXEC && !stall_in && next_pc_in[1:0] == 2'b00)
            retire_cnt <= retire_cnt + 32'd1;
         if (state == WAIT || (state == EXEC && stall_in))
            stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
